// File: rtl/aes_pad_serdes.sv
// Pad-side serialiser/deserialiser for the AES core: packs BUS_W-bit beats into key/data blocks,
// starts the core and shifts the result back out. Define AES_PAD_PARITY_EN for beat parity checks.
module aes_pad_serdes #(
  parameter int unsigned BUS_W = 8,
  parameter int unsigned BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] din,
  input  logic             din_vld,
  input  logic             din_par,
  input  logic             loadkey,
  input  logic             staenc,
  input  logic             stadec,
  output logic [BUS_W-1:0] dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             err,
  output logic [BLK_W-1:0] core_din,
  output logic [BLK_W-1:0] core_key,
  output logic             core_staenc,
  output logic             core_stadec,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_dout
);

  localparam int unsigned BEATS = BLK_W / BUS_W;
  localparam int unsigned CntW  = $clog2(BEATS + 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StShift} state_e;

  state_e           r_state, w_state_d;
  logic [BLK_W-1:0] r_key, r_data, r_out;
  logic [CntW-1:0]  r_key_cnt, r_data_cnt, r_shift_cnt;
  logic             r_mode_dec, r_err;
  logic             w_key_ok, w_data_ok, w_beat, w_par_ok, w_start;

`ifdef AES_PAD_PARITY_EN
  assign w_par_ok = ~^{din, din_par};
`else
  logic w_unused_par;
  assign w_unused_par = din_par;
  assign w_par_ok     = 1'b1;
`endif

  assign w_key_ok  = (r_key_cnt == CntW'(BEATS));
  assign w_data_ok = (r_data_cnt == CntW'(BEATS));
  assign w_beat    = (r_state == StIdle) && din_vld;
  assign w_start   = (r_state == StIdle) && (staenc ^ stadec) && w_key_ok && w_data_ok && !r_err;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_d = StStart;
      StStart: w_state_d = StWait;
      StWait:  if (core_done) w_state_d = StShift;
      StShift: if (r_shift_cnt == CntW'(BEATS - 1)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_key       <= '0;
      r_data      <= '0;
      r_out       <= '0;
      r_key_cnt   <= '0;
      r_data_cnt  <= '0;
      r_shift_cnt <= '0;
      r_mode_dec  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_beat) begin
        // Counters saturate at BEATS; the shift keeps going so the newest BEATS beats win.
        if (w_par_ok) begin
          if (loadkey) begin
            r_key <= {r_key[BLK_W-BUS_W-1:0], din};
            if (!w_key_ok) r_key_cnt <= r_key_cnt + 1'b1;
          end else begin
            r_data <= {r_data[BLK_W-BUS_W-1:0], din};
            if (!w_data_ok) r_data_cnt <= r_data_cnt + 1'b1;
          end
        end else begin
          if (loadkey) r_key_cnt <= '0;
          else         r_data_cnt <= '0;
          r_err <= 1'b1;
        end
      end
      if (w_start) r_mode_dec <= stadec;
      // Key count is kept so the same key serves following blocks.
      if (r_state == StStart) r_data_cnt <= '0;
      if (r_state == StWait && core_done) begin
        r_out       <= core_dout;
        r_shift_cnt <= '0;
      end
      if (r_state == StShift) begin
        r_out       <= r_out << BUS_W;
        r_shift_cnt <= r_shift_cnt + 1'b1;
      end
    end
  end

  assign busy        = (r_state != StIdle);
  assign dout_vld    = (r_state == StShift);
  assign dout        = dout_vld ? r_out[BLK_W-1 -: BUS_W] : '0;
  assign err         = r_err;
  assign core_din    = r_data;
  assign core_key    = r_key;
  assign core_staenc = (r_state == StStart) && !r_mode_dec;
  assign core_stadec = (r_state == StStart) && r_mode_dec;

endmodule

// File: tb/tb_aes_pad_serdes.sv
// Scoreboard bench for aes_pad_serdes: an 8-bit instance for the main flows and a 32-bit
// instance for the wide bus and parity behaviour.
module tb_aes_pad_serdes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 8-bit instance
  logic [7:0]   din = '0, dout;
  logic         din_vld = 0, din_par = 0, loadkey = 0, staenc = 0, stadec = 0;
  logic         dout_vld, busy, err, core_staenc, core_stadec, core_done;
  logic [127:0] core_din, core_key, core_dout;
  int           core_cnt;

  aes_pad_serdes #(.BUS_W(8), .BLK_W(128)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_par(din_par), .loadkey(loadkey),
    .staenc(staenc), .stadec(stadec), .dout(dout), .dout_vld(dout_vld), .busy(busy), .err(err),
    .core_din(core_din), .core_key(core_key), .core_staenc(core_staenc),
    .core_stadec(core_stadec), .core_done(core_done), .core_dout(core_dout)
  );

  always @(posedge clk) begin
    if (rst) core_cnt <= 0;
    else if (core_staenc || core_stadec) core_cnt <= 10;
    else if (core_cnt != 0) core_cnt <= core_cnt - 1;
  end
  assign core_done = (core_cnt == 1);
  assign core_dout = ~core_din;

  // 32-bit instance
  logic [31:0]  wd_din = '0, wd_dout;
  logic         wd_vld = 0, wd_par = 0, wd_loadkey = 0, wd_staenc = 0, wd_stadec = 0;
  logic         wd_dout_vld, wd_busy, wd_err, wd_core_staenc, wd_core_stadec, wd_core_done;
  logic [127:0] wd_core_din, wd_core_key, wd_core_dout;
  int           wd_cnt;

  aes_pad_serdes #(.BUS_W(32), .BLK_W(128)) u_dut_wide (
    .clk(clk), .rst(rst), .din(wd_din), .din_vld(wd_vld), .din_par(wd_par),
    .loadkey(wd_loadkey), .staenc(wd_staenc), .stadec(wd_stadec), .dout(wd_dout),
    .dout_vld(wd_dout_vld), .busy(wd_busy), .err(wd_err), .core_din(wd_core_din),
    .core_key(wd_core_key), .core_staenc(wd_core_staenc), .core_stadec(wd_core_stadec),
    .core_done(wd_core_done), .core_dout(wd_core_dout)
  );

  always @(posedge clk) begin
    if (rst) wd_cnt <= 0;
    else if (wd_core_staenc || wd_core_stadec) wd_cnt <= 3;
    else if (wd_cnt != 0) wd_cnt <= wd_cnt - 1;
  end
  assign wd_core_done = (wd_cnt == 1);
  assign wd_core_dout = ~wd_core_din;

  // Scoreboards
  logic [7:0]  sbq[$];
  logic [31:0] wsbq[$];
  int          wbeats = 0;

  always @(negedge clk) begin
    if (dout_vld) begin
      if (sbq.size() == 0) check("dout_unexpected", dout_vld, 1'b0);
      else check("dout", dout, sbq.pop_front());
    end
    if (wd_dout_vld) begin
      wbeats++;
      if (wsbq.size() == 0) check("wdout_unexpected", wd_dout_vld, 1'b0);
      else check("wdout", wd_dout, wsbq.pop_front());
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic key);
    din = d; din_par = ^d; loadkey = key; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
  endtask

  task automatic send_wbeat(input logic [31:0] d, input logic key, input logic good_par);
    wd_din = d; wd_par = good_par ? ^d : ~^d; wd_loadkey = key; wd_vld = 1'b1;
    @(posedge clk); #1;
    wd_vld = 1'b0;
  endtask

  task automatic request(input logic enc, input logic dec);
    staenc = enc; stadec = dec;
    @(posedge clk); #1;
    staenc = 1'b0; stadec = 1'b0;
  endtask

  task automatic wrequest(input logic enc);
    wd_staenc = enc; wd_stadec = ~enc;
    @(posedge clk); #1;
    wd_staenc = 1'b0; wd_stadec = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (core_done) break;
    end
    if (i == 50) check("done_timeout", core_done, 1'b1);
  endtask

  task automatic wait_idle(input bit wide);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!(wide ? wd_busy : busy)) break;
    end
    if (i == 100) check("idle_timeout", wide ? wd_busy : busy, 1'b0);
  endtask

  task automatic push_data_exp(input logic [7:0] base);
    for (int i = 0; i < 16; i++) sbq.push_back(~(base + 8'(i)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] kexp;
    logic [31:0]  wdata [4];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_dout_vld", dout_vld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_key", core_key, '0);

    // Encrypt path
    for (int i = 0; i < 16; i++) send_beat(8'(i), 1'b1);
    for (int i = 0; i < 16; i++) send_beat(8'(8'h10 + i), 1'b0);
    check("enc_key", core_key, 128'h000102030405060708090a0b0c0d0e0f);
    check("enc_din", core_din, 128'h101112131415161718191a1b1c1d1e1f);
    push_data_exp(8'h10);
    request(1'b1, 1'b0);
    @(negedge clk);
    check("enc_pulse", core_staenc, 1'b1);
    check("enc_busy", busy, 1'b1);
    @(negedge clk);
    check("enc_pulse_end", core_staenc, 1'b0);
    wait_done();
    @(negedge clk);
    check("enc_vld_after_done", dout_vld, 1'b1);
    wait_idle(1'b0);
    check("enc_sb_empty", sbq.size(), 0);

    // Key reuse with decrypt
    for (int i = 0; i < 16; i++) send_beat(8'(8'h20 + i), 1'b0);
    push_data_exp(8'h20);
    request(1'b0, 1'b1);
    @(negedge clk);
    check("dec_pulse", core_stadec, 1'b1);
    check("dec_no_enc", core_staenc, 1'b0);
    check("dec_key_kept", core_key, 128'h000102030405060708090a0b0c0d0e0f);
    wait_done();
    wait_idle(1'b0);
    check("dec_sb_empty", sbq.size(), 0);

    // Incomplete block, then simultaneous requests
    for (int i = 0; i < 15; i++) send_beat(8'(8'h30 + i), 1'b0);
    request(1'b1, 1'b0);
    @(negedge clk);
    check("inc_no_pulse", core_staenc, 1'b0);
    check("inc_busy", busy, 1'b0);
    send_beat(8'h3f, 1'b0);
    request(1'b1, 1'b1);
    @(negedge clk);
    check("both_no_pulse", core_staenc | core_stadec, 1'b0);
    check("both_busy", busy, 1'b0);

    // Reset in the middle of the output shift
    push_data_exp(8'h30);
    request(1'b1, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    check("mid_shift_vld", dout_vld, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("mrst_dout_vld", dout_vld, 1'b0);
    check("mrst_dout", dout, '0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_key", core_key, '0);
    for (int i = 0; i < 16; i++) send_beat(8'(8'h40 + i), 1'b0);
    request(1'b1, 1'b0);
    @(negedge clk);
    check("nokey_no_pulse", core_staenc, 1'b0);
    check("nokey_busy", busy, 1'b0);
    kexp = '0;
    for (int i = 0; i < 16; i++) begin
      send_beat(8'(8'h50 + i), 1'b1);
      kexp = {kexp[119:0], 8'(8'h50 + i)};
    end
    check("reload_key", core_key, kexp);
    push_data_exp(8'h40);
    request(1'b1, 1'b0);
    @(negedge clk);
    check("reload_pulse", core_staenc, 1'b1);
    wait_done();
    wait_idle(1'b0);
    check("reload_sb_empty", sbq.size(), 0);

    // Wide bus
    send_wbeat(32'h00112233, 1'b1, 1'b1);
    send_wbeat(32'h44556677, 1'b1, 1'b1);
    send_wbeat(32'h8899aabb, 1'b1, 1'b1);
    send_wbeat(32'hccddeeff, 1'b1, 1'b1);
    wdata[0] = 32'hdeadbeef; wdata[1] = 32'h01234567;
    wdata[2] = 32'h89abcdef; wdata[3] = 32'hcafef00d;
    for (int i = 0; i < 4; i++) send_wbeat(wdata[i], 1'b0, 1'b1);
    check("w_key", wd_core_key, 128'h00112233445566778899aabbccddeeff);
    check("w_din", wd_core_din, 128'hdeadbeef0123456789abcdefcafef00d);
    for (int i = 0; i < 4; i++) wsbq.push_back(~wdata[i]);
    wbeats = 0;
    wrequest(1'b1);
    @(negedge clk);
    check("w_pulse", wd_core_staenc, 1'b1);
    wait_idle(1'b1);
    check("w_beats", wbeats, 4);
    check("w_sb_empty", wsbq.size(), 0);

    // Bad parity on the second data beat
    send_wbeat(32'h11111111, 1'b0, 1'b1);
    send_wbeat(32'h22222222, 1'b0, 1'b0);
`ifdef AES_PAD_PARITY_EN
    check("par_err", wd_err, 1'b1);
    send_wbeat(32'h33333333, 1'b0, 1'b1);
    send_wbeat(32'h44444444, 1'b0, 1'b1);
    wrequest(1'b1);
    @(negedge clk);
    check("par_no_pulse", wd_core_staenc, 1'b0);
    check("par_busy", wd_busy, 1'b0);
    check("par_err_sticky", wd_err, 1'b1);
`else
    check("nopar_err", wd_err, 1'b0);
    send_wbeat(32'h33333333, 1'b0, 1'b1);
    send_wbeat(32'h44444444, 1'b0, 1'b1);
    check("nopar_din", wd_core_din, 128'h11111111222222223333333344444444);
    wsbq.push_back(32'heeeeeeee); wsbq.push_back(32'hdddddddd);
    wsbq.push_back(32'hcccccccc); wsbq.push_back(32'hbbbbbbbb);
    wrequest(1'b0);
    @(negedge clk);
    check("nopar_pulse", wd_core_stadec, 1'b1);
    wait_idle(1'b1);
    check("nopar_sb_empty", wsbq.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
